// File: rtl/rob_ring_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | rob_pkg : shared types and default sizes for the rob_ring ROB       |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
package rob_pkg;
   localparam int ROB_DEPTH      = 32;
   localparam int ROB_DISPATCH_W = 4;
   localparam int ROB_COMMIT_W   = 4;
   localparam int ROB_WB_PORTS   = 3;
   localparam int ROB_ADDR_BITS  = 64;

   typedef enum logic [1:0] {
      ST_INVALID   = 2'd0,
      ST_PENDING   = 2'd1,
      ST_DONE      = 2'd2,
      ST_EXCEPTION = 2'd3
   } rob_status_e;

   typedef struct packed {
      logic [31:0]              uop;
      logic [ROB_ADDR_BITS-1:0] pc;
      logic [4:0]               arch_dst;
      logic [6:0]               phys_dst;
      logic [6:0]               old_phys_dst;
   } rob_ent_t;
endpackage
`default_nettype wire

// File: rtl/rob_ring_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | rob_ring_if : dispatch / writeback / commit bundle of the ROB       |
// | Optional perf outputs with ROB_PERF_CNT_EN. Revision: 1.0           |
// +---------------------------------------------------------------------+
interface rob_ring_if
#(
   parameter int DEPTH      = rob_pkg::ROB_DEPTH,
   parameter int DISPATCH_W = rob_pkg::ROB_DISPATCH_W,
   parameter int COMMIT_W   = rob_pkg::ROB_COMMIT_W,
   parameter int WB_PORTS   = rob_pkg::ROB_WB_PORTS,
   parameter int ADDR_BITS  = rob_pkg::ROB_ADDR_BITS
);
   import rob_pkg::*;
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                                flush_in;
   logic [DISPATCH_W-1:0]               disp_valid_in;
   rob_ent_t [DISPATCH_W-1:0]           disp_entry_in;
   logic                                disp_ready_out;
   logic [DISPATCH_W-1:0][IDX_W-1:0]    disp_tag_out;
   logic [WB_PORTS-1:0]                 wb_valid_in;
   logic [WB_PORTS-1:0][IDX_W-1:0]      wb_tag_in;
   logic [WB_PORTS-1:0]                 wb_exc_in;
   logic [COMMIT_W-1:0]                 commit_valid_out;
   rob_ent_t [COMMIT_W-1:0]             commit_entry_out;
   logic                                redirect_valid_out;
   logic [ADDR_BITS-1:0]                redirect_pc_out;
   logic [CNT_W-1:0]                    count_out;
   logic                                empty_out;
   logic                                full_out;
`ifdef ROB_PERF_CNT_EN
   logic [63:0]                         perf_commits_out;
   logic [31:0]                         perf_flushes_out;
   logic [31:0]                         perf_full_cycles_out;
`endif

   modport master (
      output flush_in, disp_valid_in, disp_entry_in, wb_valid_in, wb_tag_in, wb_exc_in,
      input  disp_ready_out, disp_tag_out, commit_valid_out, commit_entry_out,
             redirect_valid_out, redirect_pc_out, count_out, empty_out, full_out
`ifdef ROB_PERF_CNT_EN
      , input perf_commits_out, perf_flushes_out, perf_full_cycles_out
`endif
   );

   modport slave (
      input  flush_in, disp_valid_in, disp_entry_in, wb_valid_in, wb_tag_in, wb_exc_in,
      output disp_ready_out, disp_tag_out, commit_valid_out, commit_entry_out,
             redirect_valid_out, redirect_pc_out, count_out, empty_out, full_out
`ifdef ROB_PERF_CNT_EN
      , output perf_commits_out, perf_flushes_out, perf_full_cycles_out
`endif
   );
endinterface
`default_nettype wire

// File: rtl/rob_ring_commit_window.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | rob_commit_window : contiguous-DONE scan of the entries from head   |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
module rob_commit_window
   import rob_pkg::*;
#(
   parameter int COMMIT_W = ROB_COMMIT_W,
   parameter int CNT_W    = 6
)(
   input  rob_status_e         win_status [COMMIT_W],
   input  wire logic [CNT_W-1:0] count,
   output logic [COMMIT_W-1:0] lane_mask,
   output logic [CNT_W-1:0]    commit_cnt,
   output logic                exc_at_head
);
   logic run;

   always_comb begin
      run        = 1'b1;
      lane_mask  = '0;
      commit_cnt = '0;
      for (int i = 0; i < COMMIT_W; i++) begin
         if (run && (CNT_W'(i) < count) && (win_status[i] == ST_DONE)) begin
            lane_mask[i] = 1'b1;
            commit_cnt   = commit_cnt + CNT_W'(1);
         end else begin
            run = 1'b0;
         end
      end
      exc_at_head = (count != '0) && (win_status[0] == ST_EXCEPTION);
   end
endmodule
`default_nettype wire

// File: rtl/rob_ring.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | rob_ring : circular reorder buffer with flush and PC redirect       |
// | Optional perf counters with ROB_PERF_CNT_EN. Revision: 1.0          |
// +---------------------------------------------------------------------+
module rob_ring
   import rob_pkg::*;
#(
   parameter int DEPTH      = ROB_DEPTH,
   parameter int DISPATCH_W = ROB_DISPATCH_W,
   parameter int COMMIT_W   = ROB_COMMIT_W,
   parameter int WB_PORTS   = ROB_WB_PORTS,
   parameter int ADDR_BITS  = ROB_ADDR_BITS
)(
   input wire logic clk_in,
   input wire logic rst_in,
   rob_ring_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FREE_LIM = CNT_W'(DEPTH - DISPATCH_W);

   rob_status_e          status     [DEPTH];
   rob_status_e          status_nxt [DEPTH];
   rob_ent_t             payload    [DEPTH];
   rob_status_e          win_status [COMMIT_W];
   logic [IDX_W-1:0]     head, tail;
   logic [CNT_W-1:0]     count, commit_cnt, alloc_cnt;
   logic [COMMIT_W-1:0]  lane_mask;
   logic                 exc_at_head, disp_ready, disp_fire;
   logic                 redirect_valid;
   logic [ADDR_BITS-1:0] redirect_pc;

   always_comb begin
      for (int i = 0; i < COMMIT_W; i++) win_status[i] = status[head + IDX_W'(i)];
   end

   rob_commit_window #(.COMMIT_W(COMMIT_W), .CNT_W(CNT_W)) u_window (
      .win_status  (win_status),
      .count       (count),
      .lane_mask   (lane_mask),
      .commit_cnt  (commit_cnt),
      .exc_at_head (exc_at_head)
   );

   // Ready uses registered count, so slots freed this cycle are not reused.
   assign disp_ready = (count <= FREE_LIM) && !bus.flush_in;
   assign disp_fire  = disp_ready && (|bus.disp_valid_in) && !exc_at_head;

   always_comb begin
      alloc_cnt = '0;
      for (int i = 0; i < DISPATCH_W; i++)
         if (disp_fire && bus.disp_valid_in[i]) alloc_cnt = alloc_cnt + CNT_W'(1);
   end

   always_comb begin : status_next
      logic [IDX_W-1:0] off;
      status_nxt = status;
      off        = '0;
      for (int p = 0; p < WB_PORTS; p++) begin
         off = bus.wb_tag_in[p] - head;
         if (bus.wb_valid_in[p] && (CNT_W'(off) < count)) begin
            if (bus.wb_exc_in[p])
               status_nxt[bus.wb_tag_in[p]] = ST_EXCEPTION;
            else if (status_nxt[bus.wb_tag_in[p]] != ST_EXCEPTION)
               status_nxt[bus.wb_tag_in[p]] = ST_DONE;
         end
      end
      for (int i = 0; i < COMMIT_W; i++)
         if (lane_mask[i]) status_nxt[head + IDX_W'(i)] = ST_INVALID;
      for (int i = 0; i < DISPATCH_W; i++)
         if (disp_fire && bus.disp_valid_in[i]) status_nxt[tail + IDX_W'(i)] = ST_PENDING;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in || bus.flush_in || exc_at_head) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int e = 0; e < DEPTH; e++) status[e] <= ST_INVALID;
      end else begin
         head  <= head + IDX_W'(commit_cnt);
         tail  <= tail + IDX_W'(alloc_cnt);
         count <= count + alloc_cnt - commit_cnt;
         for (int e = 0; e < DEPTH; e++) status[e] <= status_nxt[e];
      end
   end

   // The flush source owns the redirect, so a flush leaves the PC alone.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else if (bus.flush_in) begin
         redirect_valid <= 1'b0;
      end else if (exc_at_head) begin
         redirect_valid <= 1'b1;
         redirect_pc    <= ADDR_BITS'(payload[head].pc);
      end else begin
         redirect_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      for (int i = 0; i < DISPATCH_W; i++)
         if (disp_fire && bus.disp_valid_in[i]) payload[tail + IDX_W'(i)] <= bus.disp_entry_in[i];
   end

   always_comb begin
      for (int i = 0; i < COMMIT_W; i++)   bus.commit_entry_out[i] = payload[head + IDX_W'(i)];
      for (int i = 0; i < DISPATCH_W; i++) bus.disp_tag_out[i]     = tail + IDX_W'(i);
   end

   assign bus.commit_valid_out   = bus.flush_in ? '0 : lane_mask;
   assign bus.disp_ready_out     = disp_ready;
   assign bus.redirect_valid_out = redirect_valid;
   assign bus.redirect_pc_out    = redirect_pc;
   assign bus.count_out          = count;
   assign bus.empty_out          = (count == '0);
   assign bus.full_out           = (count == CNT_W'(DEPTH));

`ifdef ROB_PERF_CNT_EN
   logic [63:0] perf_commits;
   logic [31:0] perf_flushes, perf_full;
   logic [64:0] commits_sum;

   assign commits_sum = {1'b0, perf_commits} + 65'(bus.flush_in ? '0 : commit_cnt);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         perf_commits <= '0;
         perf_flushes <= '0;
         perf_full    <= '0;
      end else begin
         perf_commits <= commits_sum[64] ? '1 : commits_sum[63:0];
         if ((bus.flush_in || exc_at_head) && (perf_flushes != '1)) perf_flushes <= perf_flushes + 32'd1;
         if (bus.full_out && (perf_full != '1)) perf_full <= perf_full + 32'd1;
      end
   end

   assign bus.perf_commits_out     = perf_commits;
   assign bus.perf_flushes_out     = perf_flushes;
   assign bus.perf_full_cycles_out = perf_full;
`endif

   assert property (@(posedge clk_in) disable iff (rst_in)
      ((bus.disp_valid_in & (bus.disp_valid_in + DISPATCH_W'(1))) == '0));
endmodule
`default_nettype wire

// File: doc/rob_ring.md
Name: rob_ring

Overview:
- Parametrised circular reorder buffer, successor to the fixed-width ROB queue.
- Sits between rename/dispatch and the in-order retirement path.
- Per cycle: allocates up to DISPATCH_W entries and returns their tags; accepts WB_PORTS completion writebacks by tag; retires up to COMMIT_W contiguous DONE entries from head.
- Converts a head exception into a full flush plus a PC redirect.

Parameters:
- DEPTH, 32: number of entries; power of two, >= 4.
- DISPATCH_W, 4: max allocations per cycle; <= DEPTH.
- COMMIT_W, 4: max retirements per cycle; <= DEPTH.
- WB_PORTS, 3: completion ports.
- ADDR_BITS, 64: PC width.
- Derived: IDX_W = $clog2(DEPTH); CNT_W = $clog2(DEPTH+1).

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous, active-high reset
- flush_in  in  1  external flush (e.g. branch mispredict); empties ROB at next edge
- disp_valid_in  in  DISPATCH_W  low-justified contiguous request mask
- disp_entry_in  in  DISPATCH_W x rob_ent_t  payload: uop, pc, arch dst, phys dst, old phys dst
- disp_ready_out  out  1  high iff free slots >= DISPATCH_W and !flush_in
- disp_tag_out  out  DISPATCH_W x IDX_W  tag = tail+i, valid when lane accepted
- wb_valid_in  in  WB_PORTS  completion strobes
- wb_tag_in  in  WB_PORTS x IDX_W  completing entry tag
- wb_exc_in  in  WB_PORTS  completion raised an exception
- commit_valid_out  out  COMMIT_W  retiring lanes, low-justified
- commit_entry_out  out  COMMIT_W x rob_ent_t  retiring payloads, head-first
- redirect_valid_out  out  1  one-cycle pulse: fetch must restart
- redirect_pc_out  out  ADDR_BITS  PC of excepting uop
- count_out  out  CNT_W  occupied entries
- empty_out / full_out  out  1  count_out==0 / count_out==DEPTH

Behaviour:
- State: head, tail (IDX_W, wrap modulo DEPTH); count (CNT_W, so full and empty are distinct); per-entry status {INVALID, PENDING, DONE, EXCEPTION} plus payload.
- Reset: head=tail=count=0, all status INVALID, redirect_valid_out=0, redirect_pc_out=0. Combinational outputs are then: commit_valid_out=0, disp_ready_out=1, empty_out=1, full_out=0.
- Dispatch:
  - Fires when disp_ready_out && |disp_valid_in; all requested lanes accepted together.
  - Accepted lanes write at tail+i with status PENDING; tail += popcount.
  - Non-contiguous masks are illegal (assertion).
- Writeback:
  - Status update is visible the cycle after the edge.
  - A tag outside the occupied range [head, head+count) is ignored.
  - Two ports hitting the same tag in one cycle: EXCEPTION wins.
  - Writeback to an entry being allocated in the same cycle is illegal.
- Commit (combinational from registered state): lane i is valid iff i < count and entries head..head+i are all DONE. head advances by the number of valid lanes at the edge. Zero-latency from DONE-visible to commit.
- Exception:
  - Condition: the first non-DONE entry in the commit window sits at head and has status EXCEPTION. Lanes before it still commit in that cycle (they must be at head, so none).
  - At the edge: all entries INVALID, head=tail=count=0, redirect_valid_out=1 for one cycle, redirect_pc_out = entry pc.
  - Dispatch in that cycle is dropped.
- flush_in: highest priority. Next state equals reset state except redirect regs are untouched (the flush source owns the redirect). Dispatch, writeback and commit in that cycle are discarded; commit_valid_out forced 0 while flush_in is high.
- Simultaneous dispatch and commit: count_next = count + alloc - retire. A slot freed this cycle is not reusable this cycle because disp_ready_out uses the registered count.
- Reset mid-operation: identical to flush plus redirect regs cleared.

Optional Feature:
- Macro: ROB_PERF_CNT_EN.
- Defined: adds outputs perf_commits_out (64 b, running total of committed uops), perf_flushes_out (32 b, flush_in + exception flushes) and perf_full_cycles_out (32 b, cycles with full_out=1). All cleared by rst_in, saturating.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- rob_pkg gets rob_status_e, rob_ent_t, and ROB_DEPTH / DISPATCH_W / COMMIT_W defaults.
- One sub-module, rob_commit_window: pure combinational contiguous-DONE scan of COMMIT_W entries from head, producing the lane mask, commit count and exception-at-head flag.

Test Plan:
1. Reset, dispatch 4 uops (pc 0x100..0x10c) -> tags 0..3, count_out=4; writeback tags 0..3 -> next cycle commit_valid_out=4'b1111 in pc order, count_out=0.
2. Fill to DEPTH=32 -> full_out=1, disp_ready_out=0 from count 29 upward; wrap test: commit 8, dispatch 8 -> tags 0..7 reused, order preserved.
3. Out-of-order writeback: tags 2,3 DONE before 0 -> no commit; tag 0 then 1 DONE -> commits 1 lane, then 3 lanes.
4. Writeback tag 1 with wb_exc_in=1, tag 0 DONE -> tag 0 commits; next cycle redirect_valid_out=1, redirect_pc_out=0x104, count_out=0.
5. flush_in asserted with dispatch, writeback and commit-eligible entries all active -> nothing commits, count_out=0 next cycle, redirect_valid_out stays 0.
6. Two ports write the same tag, one with exception -> entry treated as EXCEPTION; writeback to an unoccupied tag -> no state change.
